// File: rtl/sort_ctrl_if.sv
// ---------------------------------------------------------------------------
// sort_ctrl_if -- handshake/bus bundle between the sort controller and its
// environment (plane source, bit-plane sort engine, sorted-address consumer).
//
// Groups:
//   job control   : start, busy, done
//   plane input   : plane_valid, plane_ready, plane_data[ELEMENT_NUM]
//   engine control: eng_clr, eng_load, eng_plane, eng_plane_idx, eng_update,
//                   eng_addr (largest eligible element, combinational)
//   sorted output : out_valid, out_ready, out_addr, out_last
//
// Modports:
//   master - the controller (sort_ctrl)
//   slave  - the environment around it
// ---------------------------------------------------------------------------
interface sort_ctrl_if #(
  parameter int ELEMENT_NUM      = 8,
  parameter int LOG2_ELEMENT_NUM = 3,
  parameter int LOG2_DATA_WIDTH  = 3
);
  logic                        start;
  logic                        busy;
  logic                        done;
  logic                        plane_valid;
  logic                        plane_ready;
  logic [ELEMENT_NUM-1:0]      plane_data;
  logic                        eng_clr;
  logic                        eng_load;
  logic [ELEMENT_NUM-1:0]      eng_plane;
  logic [LOG2_DATA_WIDTH-1:0]  eng_plane_idx;
  logic                        eng_update;
  logic [LOG2_ELEMENT_NUM-1:0] eng_addr;
  logic                        out_valid;
  logic                        out_ready;
  logic [LOG2_ELEMENT_NUM-1:0] out_addr;
  logic                        out_last;

  modport master (
    input  start, plane_valid, plane_data, eng_addr, out_ready,
    output busy, done, plane_ready, eng_clr, eng_load, eng_plane,
           eng_plane_idx, eng_update, out_valid, out_addr, out_last
  );

  modport slave (
    output start, plane_valid, plane_data, eng_addr, out_ready,
    input  busy, done, plane_ready, eng_clr, eng_load, eng_plane,
           eng_plane_idx, eng_update, out_valid, out_addr, out_last
  );
endinterface

// File: rtl/sort_ctrl.sv
// ---------------------------------------------------------------------------
// sort_ctrl -- job controller for a bit-plane sort engine.
//
// A job clears the engine's eligibility vector, streams DATA_WIDTH bit-planes
// (MSB plane first) into the engine, then reads ELEMENT_NUM sorted addresses
// (largest first) out of it, one per output handshake.
//
// Ports:
//   clk          - single clock, rising edge
//   rst          - synchronous, active-high reset
//   bus          - sort_ctrl_if.master (job control, plane input, engine
//                  control, sorted output)
//   perf_cycles  - [15:0] job cycle counter, only when SORT_CTRL_PERF_EN is
//                  defined; counts cycles from leaving IDLE up to the done
//                  pulse, saturates, holds in IDLE, clears on job start.
//
// Optional feature macro: SORT_CTRL_PERF_EN
// ---------------------------------------------------------------------------
module sort_ctrl #(
  parameter int ELEMENT_NUM      = 8,
  parameter int DATA_WIDTH       = 8,
  parameter int LOG2_ELEMENT_NUM = 3,
  parameter int LOG2_DATA_WIDTH  = 3
) (
  input  logic        clk,
  input  logic        rst,
  sort_ctrl_if.master bus
`ifdef SORT_CTRL_PERF_EN
  ,
  output logic [15:0] perf_cycles
`endif
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_LOAD  = 3'd2,
    ST_SORT  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [LOG2_DATA_WIDTH-1:0]  LAST_PLANE = LOG2_DATA_WIDTH'(DATA_WIDTH - 1);
  localparam logic [LOG2_ELEMENT_NUM-1:0] PENULT_OUT = LOG2_ELEMENT_NUM'(ELEMENT_NUM - 2);

  state_t                      state_r;
  logic [LOG2_DATA_WIDTH-1:0]  plane_cnt_r;
  logic [LOG2_ELEMENT_NUM-1:0] out_cnt_r;
  logic                        busy_r;
  logic                        eng_clr_r;
  logic                        plane_ready_r;
  logic                        out_valid_r;
  logic                        out_last_r;
  logic                        done_r;

  logic                        plane_hs_s;
  logic                        out_hs_s;
  logic                        last_plane_s;

  assign plane_hs_s   = bus.plane_valid & plane_ready_r;
  assign out_hs_s     = out_valid_r & bus.out_ready;
  assign last_plane_s = (plane_cnt_r == LAST_PLANE);

  // Job sequencing FSM with its registered status/strobe outputs and counters.
  // Counters stop on their final value instead of incrementing past it, so
  // they never wrap inside a job.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      plane_cnt_r   <= '0;
      out_cnt_r     <= '0;
      busy_r        <= 1'b0;
      eng_clr_r     <= 1'b0;
      plane_ready_r <= 1'b0;
      out_valid_r   <= 1'b0;
      out_last_r    <= 1'b0;
      done_r        <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.start) begin
            state_r     <= ST_CLEAR;
            busy_r      <= 1'b1;
            eng_clr_r   <= 1'b1;
            plane_cnt_r <= '0;
            out_cnt_r   <= '0;
          end
        end
        ST_CLEAR: begin
          state_r       <= ST_LOAD;
          eng_clr_r     <= 1'b0;
          plane_ready_r <= 1'b1;
        end
        ST_LOAD: begin
          if (plane_hs_s) begin
            if (last_plane_s) begin
              state_r       <= ST_SORT;
              plane_ready_r <= 1'b0;
              out_valid_r   <= 1'b1;
              out_last_r    <= 1'b0;
            end else begin
              plane_cnt_r <= plane_cnt_r + LOG2_DATA_WIDTH'(1);
            end
          end
        end
        ST_SORT: begin
          if (out_hs_s) begin
            if (out_last_r) begin
              state_r     <= ST_DONE;
              out_valid_r <= 1'b0;
              out_last_r  <= 1'b0;
              done_r      <= 1'b1;
            end else begin
              out_cnt_r  <= out_cnt_r + LOG2_ELEMENT_NUM'(1);
              // out_last tracks "counter == ELEMENT_NUM-1" one step ahead.
              out_last_r <= (out_cnt_r == PENULT_OUT);
            end
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r       <= ST_IDLE;
          busy_r        <= 1'b0;
          eng_clr_r     <= 1'b0;
          plane_ready_r <= 1'b0;
          out_valid_r   <= 1'b0;
          out_last_r    <= 1'b0;
          done_r        <= 1'b0;
        end
      endcase
    end
  end

  // Load/update strobes must coincide with their handshakes, so they are
  // decoded from registered ready/valid plus the partner's input. Data paths
  // are gated so they read zero whenever the matching strobe/valid is low.
  assign bus.busy          = busy_r;
  assign bus.done          = done_r;
  assign bus.eng_clr       = eng_clr_r;
  assign bus.plane_ready   = plane_ready_r;
  assign bus.eng_load      = plane_hs_s;
  assign bus.eng_plane     = plane_hs_s ? bus.plane_data : {ELEMENT_NUM{1'b0}};
  assign bus.eng_plane_idx = plane_cnt_r;
  assign bus.eng_update    = out_hs_s;
  assign bus.out_valid     = out_valid_r;
  assign bus.out_addr      = out_valid_r ? bus.eng_addr : {LOG2_ELEMENT_NUM{1'b0}};
  assign bus.out_last      = out_last_r;

`ifdef SORT_CTRL_PERF_EN
  logic [15:0] perf_cnt_r;

  // Job cycle counter: cleared when a job is accepted, then counts every
  // non-IDLE cycle (CLEAR through DONE inclusive), saturating at all ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_cnt_r <= 16'd0;
    end else if ((state_r == ST_IDLE) && bus.start) begin
      perf_cnt_r <= 16'd0;
    end else if ((state_r != ST_IDLE) && (perf_cnt_r != 16'hFFFF)) begin
      perf_cnt_r <= perf_cnt_r + 16'd1;
    end
  end

  assign perf_cycles = perf_cnt_r;
`endif

endmodule

// File: tb/tb_sort_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sort_ctrl -- self-checking bench for sort_ctrl.
// Contains a behavioural bit-plane engine (keys rebuilt from loaded planes,
// eligibility vector, largest-eligible address, lowest index wins ties) and a
// rank-based reference sort for expected address order.
// ---------------------------------------------------------------------------
module tb_sort_ctrl;
  localparam int EN  = 8;
  localparam int DW  = 8;
  localparam int L2E = 3;
  localparam int L2D = 3;

  typedef logic [EN-1:0][DW-1:0]  keys_t;
  typedef logic [EN-1:0][L2E-1:0] order_t;

  typedef struct {
    keys_t  keys;
    order_t exp;
    int     gap;
    int     stall_k;
    int     stall_len;
    bit     poke_start;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  sort_ctrl_if #(.ELEMENT_NUM(EN), .LOG2_ELEMENT_NUM(L2E), .LOG2_DATA_WIDTH(L2D)) bus ();

`ifdef SORT_CTRL_PERF_EN
  logic [15:0] perf_cycles;
  sort_ctrl #(.ELEMENT_NUM(EN), .DATA_WIDTH(DW), .LOG2_ELEMENT_NUM(L2E), .LOG2_DATA_WIDTH(L2D))
    dut (.clk(clk), .rst(rst), .bus(bus), .perf_cycles(perf_cycles));
`else
  sort_ctrl #(.ELEMENT_NUM(EN), .DATA_WIDTH(DW), .LOG2_ELEMENT_NUM(L2E), .LOG2_DATA_WIDTH(L2D))
    dut (.clk(clk), .rst(rst), .bus(bus));
`endif

  always #5 clk = ~clk;

  // ---------------- behavioural engine ----------------
  keys_t        eng_keys = '0;
  logic [EN-1:0] elig    = '0;

  always @(posedge clk) begin
    if (bus.eng_clr) elig <= '1;
    if (bus.eng_load) begin
      for (int i = 0; i < EN; i++)
        eng_keys[i][DW-1-int'(bus.eng_plane_idx)] <= bus.eng_plane[i];
    end
    if (bus.eng_update) elig[bus.eng_addr] <= 1'b0;
  end

  always_comb begin
    int best;
    best = 0;
    for (int i = EN - 1; i >= 0; i--)
      if (elig[i] && (!elig[best] || eng_keys[i] >= eng_keys[best])) best = i;
    bus.eng_addr = L2E'(best);
  end

  // ---------------- reference sort ----------------
  function automatic order_t ref_order(input keys_t k);
    order_t o;
    o = '0;
    for (int i = 0; i < EN; i++) begin
      int rank;
      rank = 0;
      for (int j = 0; j < EN; j++)
        if (k[j] > k[i] || (k[j] == k[i] && j < i)) rank++;
      o[rank] = L2E'(i);
    end
    return o;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full job; abort_k >= 0 asserts rst instead of the abort_k-th handshake.
  task automatic run_job(input vec_t v, input int abort_k);
    int cyc;
    logic [EN-1:0] pd;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    cyc = 0;
    chk("clr_busy", {31'd0, bus.busy}, 32'd1);
    chk("clr_pulse", {31'd0, bus.eng_clr}, 32'd1);
    chk("clr_no_ready", {31'd0, bus.plane_ready}, 32'd0);
    tick(); cyc++;
    chk("clr_one_cycle", {31'd0, bus.eng_clr}, 32'd0);
    for (int p = 0; p < DW; p++) begin
      for (int g = 0; g < v.gap; g++) begin
        bus.plane_valid = 1'b0;
        bus.start = v.poke_start;
        #1;
        chk("gap_ready", {31'd0, bus.plane_ready}, 32'd1);
        chk("gap_no_load", {31'd0, bus.eng_load}, 32'd0);
        tick(); cyc++;
        bus.start = 1'b0;
        chk("gap_no_sort", {31'd0, bus.out_valid}, 32'd0);
      end
      for (int i = 0; i < EN; i++) pd[i] = v.keys[i][DW-1-p];
      bus.plane_valid = 1'b1;
      bus.plane_data  = pd;
      #1;
      chk("load_pulse", {31'd0, bus.eng_load}, 32'd1);
      chk("load_idx", {29'd0, bus.eng_plane_idx}, p);
      chk("load_plane", {24'd0, bus.eng_plane}, {24'd0, pd});
      tick(); cyc++;
    end
    bus.plane_valid = 1'b0;
    bus.plane_data  = '0;
    chk("sort_no_ready", {31'd0, bus.plane_ready}, 32'd0);
    for (int k = 0; k < EN; k++) begin
      if (k == abort_k) begin
        bus.out_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_idx", {29'd0, bus.eng_plane_idx}, 32'd0);
`ifdef SORT_CTRL_PERF_EN
        chk("rst_perf", {16'd0, perf_cycles}, 32'd0);
`endif
        return;
      end
      if (k == v.stall_k) begin
        for (int s = 0; s < v.stall_len; s++) begin
          bus.out_ready = 1'b0;
          #1;
          chk("stall_valid", {31'd0, bus.out_valid}, 32'd1);
          chk("stall_addr", {29'd0, bus.out_addr}, {29'd0, v.exp[k]});
          chk("stall_no_upd", {31'd0, bus.eng_update}, 32'd0);
          tick(); cyc++;
        end
      end
      bus.out_ready = 1'b1;
      #1;
      chk("out_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("out_addr", {29'd0, bus.out_addr}, {29'd0, v.exp[k]});
      chk("out_last", {31'd0, bus.out_last}, (k == EN - 1) ? 32'd1 : 32'd0);
      chk("out_update", {31'd0, bus.eng_update}, 32'd1);
      tick(); cyc++;
    end
    bus.out_ready = 1'b0;
    bus.start = v.poke_start;
    #1;
    chk("done_pulse", {31'd0, bus.done}, 32'd1);
    chk("done_busy", {31'd0, bus.busy}, 32'd1);
    chk("done_no_valid", {31'd0, bus.out_valid}, 32'd0);
    tick(); cyc++;
    bus.start = 1'b0;
    chk("done_one_cycle", {31'd0, bus.done}, 32'd0);
    chk("idle_busy", {31'd0, bus.busy}, 32'd0);
    chk("job_cycles", cyc, 1 + DW + EN + 1 + DW * v.gap + v.stall_len);
`ifdef SORT_CTRL_PERF_EN
    chk("perf_cycles", {16'd0, perf_cycles}, cyc);
`endif
    tick();
    chk("idle_stays", {31'd0, bus.busy}, 32'd0);
`ifdef SORT_CTRL_PERF_EN
    chk("perf_hold", {16'd0, perf_cycles}, cyc);
`endif
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[5];
    vec_t rv;
    bus.start = 1'b0; bus.plane_valid = 1'b0; bus.plane_data = '0; bus.out_ready = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    chk("rst0_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst0_ready", {31'd0, bus.plane_ready}, 32'd0);
    chk("rst0_clr", {31'd0, bus.eng_clr}, 32'd0);
    chk("rst0_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst0_last", {31'd0, bus.out_last}, 32'd0);
    chk("rst0_done", {31'd0, bus.done}, 32'd0);
    chk("rst0_plane", {24'd0, bus.eng_plane}, 32'd0);
    chk("rst0_idx", {29'd0, bus.eng_plane_idx}, 32'd0);
    chk("rst0_addr", {29'd0, bus.out_addr}, 32'd0);
    rst = 1'b0;
    tick();

    // Directed table: basic sort, stalled 2nd address, gapped planes,
    // all-equal keys, ascending keys with start poked while busy.
    vecs[0] = '{keys: {8'd64, 8'd0, 8'd255, 8'd5, 8'd90, 8'd17, 8'd200, 8'd3},
                exp: {3'd6, 3'd0, 3'd4, 3'd2, 3'd7, 3'd3, 3'd1, 3'd5},
                gap: 0, stall_k: -1, stall_len: 0, poke_start: 1'b0};
    vecs[1] = vecs[0];
    vecs[1].stall_k = 1; vecs[1].stall_len = 3;
    vecs[2] = vecs[0];
    vecs[2].gap = 2;
    vecs[3] = '{keys: {8{8'd7}},
                exp: {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0},
                gap: 0, stall_k: -1, stall_len: 0, poke_start: 1'b0};
    vecs[4] = '{keys: {8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0},
                exp: {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7},
                gap: 1, stall_k: 4, stall_len: 2, poke_start: 1'b1};
    for (int v = 0; v < 5; v++) run_job(vecs[v], -1);

    // Reset after four outputs, then a complete job.
    run_job(vecs[0], 4);
    tick();
    run_job(vecs[0], -1);

    // Randomised jobs against the reference sort.
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < EN; i++) rv.keys[i] = DW'($urandom_range(0, 255));
      rv.exp        = ref_order(rv.keys);
      rv.gap        = int'($urandom_range(0, 2));
      rv.stall_k    = int'($urandom_range(0, EN - 1));
      rv.stall_len  = int'($urandom_range(0, 3));
      rv.poke_start = 1'($urandom_range(0, 1));
      run_job(rv, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/sort_ctrl.md
SORT_CTRL -- requirements
Module: sort_ctrl

Interface
REQ-001 Parameter ELEMENT_NUM, default 8, number of keys sorted per job (power of two, >=2).
REQ-002 Parameter DATA_WIDTH, default 8, key width in bits, which is also the number of bit-planes per job.
REQ-003 Parameter LOG2_ELEMENT_NUM, default 3; parameter LOG2_DATA_WIDTH, default 3.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start  input  1  job request; accepted only in IDLE.
REQ-007 busy  output  1  high in every state except IDLE.
REQ-008 plane_valid  input  1  a bit-plane is offered on plane_data.
REQ-009 plane_ready  output  1  controller accepts a plane this cycle.
REQ-010 plane_data  input  ELEMENT_NUM  one bit-plane, MSB plane first, bit i belongs to element i.
REQ-011 eng_clr  output  1  one-cycle pulse that sets the engine's eligibility vector to all ones.
REQ-012 eng_load  output  1  engine captures eng_plane into plane slot eng_plane_idx.
REQ-013 eng_plane  output  ELEMENT_NUM  plane forwarded to the engine.
REQ-014 eng_plane_idx  output  LOG2_DATA_WIDTH  target plane slot, 0 = MSB plane.
REQ-015 eng_update  output  1  engine clears the current largest element from its eligibility vector.
REQ-016 eng_addr  input  LOG2_ELEMENT_NUM  largest-element address from the engine (combinational).
REQ-017 out_valid  output  1  out_addr holds the next sorted address.
REQ-018 out_ready  input  1  downstream consumer accepts out_addr.
REQ-019 out_addr  output  LOG2_ELEMENT_NUM  sorted address, largest first.
REQ-020 out_last  output  1  high with the final (ELEMENT_NUM-th) address.
REQ-021 done  output  1  one-cycle pulse after the last address is accepted.

Function
REQ-022 FSM states SHALL be IDLE, CLEAR, LOAD, SORT and DONE.
REQ-023 IDLE->CLEAR on start; in CLEAR, eng_clr=1 for exactly one cycle, then ->LOAD.
REQ-024 In LOAD, plane_ready=1, and each cycle with plane_valid&plane_ready SHALL pulse eng_load with eng_plane=plane_data and eng_plane_idx=plane count, then increment the count.
REQ-025 Acceptance of plane DATA_WIDTH-1 SHALL move to SORT on the next edge; LOAD has no cycle limit when plane_valid is absent.
REQ-026 In SORT, out_valid=1 and out_addr=eng_addr; out_addr SHALL be stable while out_valid&~out_ready.
REQ-027 eng_update SHALL equal out_valid&out_ready, so the engine advances only on a handshake.
REQ-028 An output counter SHALL increment per handshake; out_last=1 when it equals ELEMENT_NUM-1.
REQ-029 The handshake with out_last=1 SHALL move to DONE; DONE asserts done for one cycle, then ->IDLE.
REQ-030 start SHALL be ignored whenever busy=1; plane_ready and out_valid SHALL be 0 outside LOAD and SORT respectively.
REQ-031 A job SHALL take 1 + DATA_WIDTH + ELEMENT_NUM + 1 cycles with no stalls.
REQ-032 Counters SHALL never wrap within a job; both clear on entry to CLEAR.

Reset
REQ-033 On rst, at any point mid-job, the next state SHALL be IDLE with both counters 0.
REQ-034 Outputs busy, plane_ready, eng_clr, eng_load, eng_update, out_valid, out_last and done SHALL be 0 after rst; eng_plane, eng_plane_idx and out_addr SHALL be 0.

Configuration
REQ-035 With SORT_CTRL_PERF_EN defined, add output perf_cycles [15:0], which counts the cycles from leaving IDLE up to the done pulse (saturating at 16'hFFFF), holds its value in IDLE, clears on entry to CLEAR, and is 0 on rst.
REQ-036 Without SORT_CTRL_PERF_EN, the port and its counter SHALL NOT exist; all other behaviour is identical.

Verification
REQ-037 Defaults, start, 8 planes with plane_valid held 1 and out_ready held 1 -> done pulses exactly 18 cycles after start is sampled; 8 eng_update pulses are observed.
REQ-038 Keys {3,200,17,90,5,255,0,64} with an engine model -> out_addr sequence 5,1,3,7,2,4,0,6, with out_last only on the 6.
REQ-039 out_ready low for 3 cycles on the 2nd address -> out_addr holds 1, no eng_update during the stall, sequence unchanged.
REQ-040 plane_valid gapped (1,0,0,1,...) -> eng_plane_idx increments 0..7 with no skips; SORT is entered only after the 8th plane.
REQ-041 rst asserted during SORT after 4 outputs -> next cycle busy=0 and out_valid=0; a new start yields a full 8-address job.
REQ-042 With SORT_CTRL_PERF_EN defined, the REQ-037 run -> perf_cycles=18 in IDLE after done; start pulsed while busy -> no effect.
